// File: rtl/reg_file_mp.sv
// Multi-read-port register file with optional write bypass, hardwired zero
// register, per-register pending-write scoreboard and a sequential clear engine.
module reg_file_mp #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     RF_WD,
    input  logic [AW-1:0]        RF_WA,
    input  logic                 RF_EN,
    input  logic [NRD*AW-1:0]    RF_ADR,
    output logic [NRD*WIDTH-1:0] RF_RS,
    output logic [NRD-1:0]       RF_PEND,
    input  logic                 RF_RSV_EN,
    input  logic [AW-1:0]        RF_RSV_ADR,
    input  logic                 RF_CLR,
    output logic                 RF_CLR_BUSY
);

    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    // Register 0 is skipped by the sweep when it is hardwired to zero.
    localparam logic [AW-1:0] CntFirst = (ZERO_REG != 0) ? AW'(1) : AW'(0);
    localparam logic [AW-1:0] CntLast  = AW'(DEPTH - 1);

    state_e           r_state;
    state_e           w_state_d;
    logic [AW-1:0]    r_cnt;
    logic [AW-1:0]    w_cnt_d;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_pend;

    logic w_idle;
    logic w_wr_ok;
    logic w_rsv_ok;

    // An address is usable if it exists and is not the hardwired zero register.
    function automatic logic f_valid(input logic [AW-1:0] a);
        f_valid = (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign w_idle      = (r_state == StIdle);
    assign w_wr_ok     = RF_EN && w_idle && f_valid(RF_WA);
    assign w_rsv_ok    = RF_RSV_EN && w_idle && f_valid(RF_RSV_ADR);
    assign RF_CLR_BUSY = (r_state == StSweep);

    // Clear FSM state and sweep counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Clear FSM next-state and counter logic.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (RF_CLR) begin
                    w_state_d = StSweep;
                    w_cnt_d   = CntFirst;
                end
            end
            StSweep: begin
                if (r_cnt == CntLast) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    // Register array: sweep clears take priority; writes only when idle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == StSweep) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_ok) begin
            r_mem[RF_WA] <= RF_WD;
        end
    end

    // Pending scoreboard: reserve is applied after the write clear so it wins.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pend <= '0;
        end else if (r_state == StSweep) begin
            r_pend[r_cnt] <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_pend[RF_WA] <= 1'b0;
            end
            if (w_rsv_ok) begin
                r_pend[RF_RSV_ADR] <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < int'(NRD); g++) begin : g_rd
        logic [AW-1:0]    w_addr;
        logic [WIDTH-1:0] w_data;

        assign w_addr = RF_ADR[g*AW +: AW];

        // Asynchronous read with optional same-cycle forwarding of the write.
        always_comb begin
            w_data = '0;
            if (f_valid(w_addr)) begin
                w_data = r_mem[w_addr];
            end
            if ((BYPASS != 0) && w_wr_ok && (RF_WA == w_addr)) begin
                w_data = RF_WD;
            end
        end

        assign RF_RS[g*WIDTH +: WIDTH] = w_data;
        assign RF_PEND[g]              = f_valid(w_addr) ? r_pend[w_addr] : 1'b0;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: a default instance (BYPASS, ZERO_REG) and
// a small corner instance (16x12, three ports, no bypass, no zero register).
module tb_reg_file_mp;

    logic CLK = 1'b0;
    logic RST;

    // Default instance signals
    logic [31:0] m_wd;
    logic [4:0]  m_wa;
    logic        m_en;
    logic [9:0]  m_adr;
    logic [63:0] m_rs;
    logic [1:0]  m_pend;
    logic        m_rsv_en;
    logic [4:0]  m_rsv_adr;
    logic        m_clr;
    logic        m_busy;

    // Corner instance signals
    logic [15:0] c_wd;
    logic [3:0]  c_wa;
    logic        c_en;
    logic [11:0] c_adr;
    logic [47:0] c_rs;
    logic [2:0]  c_pend;
    logic        c_rsv_en;
    logic [3:0]  c_rsv_adr;
    logic        c_clr;
    logic        c_busy;

    int checks   = 0;
    int failures = 0;

    // Expectation queues; sig: 0 m_rs 1 m_pend 2 m_busy 3 c_rs 4 c_pend 5 c_busy
    string       q_name[$];
    int          q_sig[$];
    int          q_idx[$];
    logic [31:0] q_exp[$];

    always #5 CLK = ~CLK;

    reg_file_mp u_main (
        .CLK         (CLK),
        .RST         (RST),
        .RF_WD       (m_wd),
        .RF_WA       (m_wa),
        .RF_EN       (m_en),
        .RF_ADR      (m_adr),
        .RF_RS       (m_rs),
        .RF_PEND     (m_pend),
        .RF_RSV_EN   (m_rsv_en),
        .RF_RSV_ADR  (m_rsv_adr),
        .RF_CLR      (m_clr),
        .RF_CLR_BUSY (m_busy)
    );

    reg_file_mp #(
        .WIDTH    (16),
        .DEPTH    (12),
        .NRD      (3),
        .BYPASS   (0),
        .ZERO_REG (0)
    ) u_corner (
        .CLK         (CLK),
        .RST         (RST),
        .RF_WD       (c_wd),
        .RF_WA       (c_wa),
        .RF_EN       (c_en),
        .RF_ADR      (c_adr),
        .RF_RS       (c_rs),
        .RF_PEND     (c_pend),
        .RF_RSV_EN   (c_rsv_en),
        .RF_RSV_ADR  (c_rsv_adr),
        .RF_CLR      (c_clr),
        .RF_CLR_BUSY (c_busy)
    );

    task automatic exp_chk(input string n, input int s, input int i, input logic [31:0] e);
        q_name.push_back(n);
        q_sig.push_back(s);
        q_idx.push_back(i);
        q_exp.push_back(e);
    endtask

    // Inputs change just after the rising edge; the monitor samples at the falling edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic madr(input logic [4:0] a0, input logic [4:0] a1);
        m_adr = {a1, a0};
    endtask

    task automatic cadr(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        c_adr = {a2, a1, a0};
    endtask

    // Monitor: drain every expectation queued for this cycle.
    always @(negedge CLK) begin
        while (q_sig.size() > 0) begin
            string       n;
            int          s;
            int          i;
            logic [31:0] e;
            logic [31:0] act;
            n = q_name.pop_front();
            s = q_sig.pop_front();
            i = q_idx.pop_front();
            e = q_exp.pop_front();
            case (s)
                0:       act = m_rs[i*32 +: 32];
                1:       act = {31'b0, m_pend[i]};
                2:       act = {31'b0, m_busy};
                3:       act = {16'b0, c_rs[i*16 +: 16]};
                4:       act = {31'b0, c_pend[i]};
                default: act = {31'b0, c_busy};
            endcase
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s: got %h expected %h at %0t", n, act, e, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1;
        m_wd = '0; m_wa = '0; m_en = 1'b0; m_adr = '0;
        m_rsv_en = 1'b0; m_rsv_adr = '0; m_clr = 1'b0;
        c_wd = '0; c_wa = '0; c_en = 1'b0; c_adr = '0;
        c_rsv_en = 1'b0; c_rsv_adr = '0; c_clr = 1'b0;

        // Reset state
        cyc();
        exp_chk("rst_rs0", 0, 0, 0);
        exp_chk("rst_rs1", 0, 1, 0);
        exp_chk("rst_pend0", 1, 0, 0);
        exp_chk("rst_busy", 2, 0, 0);
        exp_chk("rst_c_rs2", 3, 2, 0);
        exp_chk("rst_c_busy", 5, 0, 0);
        cyc();
        RST = 1'b0;

        // Write then asynchronous reset mid-cycle
        cyc();
        m_en = 1'b1; m_wa = 5'd4; m_wd = 32'h0000_CAFE; madr(5'd4, 5'd0);
        exp_chk("pre_rst_bypass", 0, 0, 32'h0000_CAFE);
        cyc();
        m_en = 1'b0;
        exp_chk("pre_rst_stored", 0, 0, 32'h0000_CAFE);
        cyc();
        #1 RST = 1'b1;
        exp_chk("mid_rst_rs0", 0, 0, 0);
        exp_chk("mid_rst_busy", 2, 0, 0);
        cyc();
        RST = 1'b0;

        // Write to x0 is dropped and never bypassed
        cyc();
        m_en = 1'b1; m_wa = 5'd0; m_wd = 32'hDEAD_BEEF; madr(5'd0, 5'd0);
        exp_chk("x0_bypass", 0, 0, 0);
        cyc();
        m_en = 1'b0;
        exp_chk("x0_after_wr", 0, 0, 0);

        // Write/read/bypass
        cyc();
        m_en = 1'b1; m_wa = 5'd5; m_wd = 32'h1234_5678; madr(5'd5, 5'd6);
        exp_chk("byp_rs0", 0, 0, 32'h1234_5678);
        exp_chk("byp_rs1_other", 0, 1, 0);
        cyc();
        m_wa = 5'd6; m_wd = 32'hA5A5_A5A5;
        exp_chk("stored_rs0", 0, 0, 32'h1234_5678);
        exp_chk("byp_rs1", 0, 1, 32'hA5A5_A5A5);
        cyc();
        m_en = 1'b0;
        exp_chk("stored_rs1", 0, 1, 32'hA5A5_A5A5);
        exp_chk("pend_x5", 1, 0, 0);

        // Scoreboard
        cyc();
        m_rsv_en = 1'b1; m_rsv_adr = 5'd7; madr(5'd0, 5'd7);
        exp_chk("rsv_not_yet", 1, 1, 0);
        cyc();
        m_rsv_en = 1'b0;
        exp_chk("rsv_set", 1, 1, 1);
        cyc();
        m_en = 1'b1; m_wa = 5'd7; m_wd = 32'h77;
        exp_chk("rsv_hold", 1, 1, 1);
        exp_chk("wr7_bypass", 0, 1, 32'h77);
        cyc();
        m_en = 1'b0;
        exp_chk("wr_clears_pend", 1, 1, 0);
        exp_chk("wr7_stored", 0, 1, 32'h77);
        cyc();
        m_rsv_en = 1'b1; m_rsv_adr = 5'd7; m_en = 1'b1; m_wa = 5'd7; m_wd = 32'h78;
        cyc();
        m_rsv_en = 1'b0; m_en = 1'b0;
        exp_chk("rsv_wins", 1, 1, 1);
        exp_chk("rsv_wr_data", 0, 1, 32'h78);
        cyc();
        m_rsv_en = 1'b1; m_rsv_adr = 5'd0; madr(5'd0, 5'd7);
        cyc();
        m_rsv_en = 1'b0;
        exp_chk("rsv_x0_ignored", 1, 0, 0);

        // Fill x1..x31 with their index, then reserve x9 and x20
        for (int k = 1; k < 32; k++) begin
            cyc();
            m_en = 1'b1; m_wa = 5'(k); m_wd = 32'(k);
        end
        cyc();
        m_en = 1'b0; madr(5'd31, 5'd3);
        exp_chk("fill_x31", 0, 0, 31);
        exp_chk("fill_x3", 0, 1, 3);
        cyc();
        m_rsv_en = 1'b1; m_rsv_adr = 5'd9;
        cyc();
        m_rsv_adr = 5'd20;
        cyc();
        m_rsv_en = 1'b0; madr(5'd9, 5'd20);
        exp_chk("pend_x9", 1, 0, 1);
        exp_chk("pend_x20", 1, 1, 1);

        // Clear sweep: busy for exactly 31 cycles, reg j cleared at end of busy cycle j
        cyc();
        m_clr = 1'b1;
        exp_chk("sweep_start_busy", 2, 0, 0);
        for (int j = 1; j < 32; j++) begin
            cyc();
            m_clr = (j == 5);
            m_en = (j == 10); m_wa = 5'd9; m_wd = 32'hAA;
            m_rsv_en = (j == 10); m_rsv_adr = 5'd9;
            madr(5'(j), 5'(j - 1));
            exp_chk("sweep_busy", 2, 0, 1);
            exp_chk("sweep_not_yet", 0, 0, 32'(j));
            exp_chk("sweep_cleared", 0, 1, 0);
        end
        cyc();
        m_clr = 1'b0; m_en = 1'b0; m_rsv_en = 1'b0; madr(5'd31, 5'd9);
        exp_chk("sweep_done_busy", 2, 0, 0);
        exp_chk("sweep_x31", 0, 0, 0);
        exp_chk("sweep_x9_no_wr", 0, 1, 0);
        exp_chk("sweep_pend_x9", 1, 1, 0);
        cyc();
        madr(5'd20, 5'd3);
        exp_chk("sweep_pend_x20", 1, 0, 0);
        exp_chk("sweep_x3", 0, 1, 0);
        exp_chk("no_restart_busy", 2, 0, 0);

        // Reset mid-sweep
        cyc();
        m_en = 1'b1; m_wa = 5'd30; m_wd = 32'h3030_3030;
        cyc();
        m_en = 1'b0; m_clr = 1'b1;
        for (int j = 1; j < 10; j++) begin
            cyc();
            m_clr = 1'b0;
            exp_chk("sweep2_busy", 2, 0, 1);
        end
        cyc();
        madr(5'd30, 5'd1);
        #1 RST = 1'b1;
        exp_chk("abort_busy", 2, 0, 0);
        exp_chk("abort_x30", 0, 0, 0);
        exp_chk("abort_x1", 0, 1, 0);
        cyc();
        RST = 1'b0; m_en = 1'b1; m_wa = 5'd2; m_wd = 32'h55;
        cyc();
        m_en = 1'b0; madr(5'd2, 5'd30);
        exp_chk("post_abort_x2", 0, 0, 32'h55);
        exp_chk("post_abort_x30", 0, 1, 0);
        exp_chk("post_abort_busy", 2, 0, 0);
        cyc();
        exp_chk("post_abort_idle", 2, 0, 0);

        // Corner instance: x0 writable, no bypass, out-of-range address ignored
        cyc();
        c_en = 1'b1; c_wa = 4'd0; c_wd = 16'hBEEF; cadr(4'd0, 4'd13, 4'd11);
        exp_chk("c_no_bypass", 3, 0, 0);
        cyc();
        c_wa = 4'd13; c_wd = 16'h1234;
        exp_chk("c_x0_written", 3, 0, 32'hBEEF);
        exp_chk("c_oor_read", 3, 1, 0);
        cyc();
        c_wa = 4'd11; c_wd = 16'h0B0B;
        exp_chk("c_oor_write", 3, 1, 0);
        exp_chk("c_x11_no_bypass", 3, 2, 0);
        cyc();
        c_en = 1'b0;
        exp_chk("c_x11", 3, 2, 32'h0B0B);
        cyc();
        c_rsv_en = 1'b1; c_rsv_adr = 4'd0;
        cyc();
        c_rsv_adr = 4'd13;
        exp_chk("c_pend_x0", 4, 0, 1);
        cyc();
        c_rsv_en = 1'b0;
        exp_chk("c_pend_oor", 4, 1, 0);
        exp_chk("c_pend_x0_hold", 4, 0, 1);

        // Corner sweep covers x0 and lasts 12 cycles
        cyc();
        c_clr = 1'b1;
        exp_chk("c_sweep_start", 5, 0, 0);
        for (int j = 1; j < 13; j++) begin
            cyc();
            c_clr = 1'b0;
            exp_chk("c_sweep_busy", 5, 0, 1);
            if (j == 1) exp_chk("c_x0_before_clr", 3, 0, 32'hBEEF);
            if (j == 2) exp_chk("c_x0_after_clr", 3, 0, 0);
        end
        cyc();
        exp_chk("c_sweep_done", 5, 0, 0);
        exp_chk("c_sweep_x0", 3, 0, 0);
        exp_chk("c_sweep_x11", 3, 2, 0);
        exp_chk("c_sweep_pend_x0", 4, 0, 0);

        cyc();
        @(negedge CLK);
        #1;
        if (q_sig.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q_sig.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
